// File: rtl/mu0_control.sv
// MU0 fetch/execute sequencer: decodes the IR opcode and steers the ALU, the
// datapath muxes and the memory Rd/Wr handshake through FETCH, EXECUTE and HALT.
module mu0_control #(
    parameter bit MEM_HANDSHAKE = 1'b1
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [3:0] F,
    input  logic       N,
    input  logic       Z,
    input  logic       MemAck,
    output logic [1:0] M,
    output logic       X_sel,
    output logic       Y_sel,
    output logic       Addr_sel,
    output logic       PC_En,
    output logic       IR_En,
    output logic       Acc_En,
    output logic       Rd,
    output logic       Wr,
    output logic       Fetch,
    output logic       Halted
);

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        EXECUTE = 2'd1,
        HALT    = 2'd2
    } state_t;

    state_t state, next_state;
    logic   ack;

    assign ack = MEM_HANDSHAKE ? MemAck : 1'b1;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state <= FETCH;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        M          = 2'b00;
        X_sel      = 1'b0;
        Y_sel      = 1'b0;
        Addr_sel   = 1'b0;
        PC_En      = 1'b0;
        IR_En      = 1'b0;
        Acc_En     = 1'b0;
        Rd         = 1'b0;
        Wr         = 1'b0;
        Fetch      = 1'b0;
        Halted     = 1'b0;

        case (state)
            FETCH: begin
                Fetch = 1'b1;
                Rd    = 1'b1;
                X_sel = 1'b1;
                M     = 2'b10;
                IR_En = ack;
                PC_En = ack;
                if (ack) next_state = EXECUTE;
            end

            EXECUTE: begin
                case (F)
                    4'h0, 4'h2, 4'h3: begin
                        Addr_sel = 1'b1;
                        Rd       = 1'b1;
                        Acc_En   = ack;
                        case (F)
                            4'h2:    M = 2'b01;
                            4'h3:    M = 2'b11;
                            default: M = 2'b00;
                        endcase
                        if (ack) next_state = FETCH;
                    end
                    4'h1: begin
                        Addr_sel = 1'b1;
                        Wr       = 1'b1;
                        if (ack) next_state = FETCH;
                    end
                    4'h4, 4'h5, 4'h6: begin
                        Y_sel      = 1'b1;
                        next_state = FETCH;
                        case (F)
                            4'h5:    PC_En = ~N;
                            4'h6:    PC_En = ~Z;
                            default: PC_En = 1'b1;
                        endcase
                    end
                    4'h7:    next_state = HALT;
                    default: next_state = FETCH;
                endcase
            end

            HALT: Halted = 1'b1;

            default: next_state = FETCH;
        endcase

        // Reset overrides the decode so nothing fires while the state register is held
        if (Reset) begin
            M        = 2'b00;
            X_sel    = 1'b0;
            Y_sel    = 1'b0;
            Addr_sel = 1'b0;
            PC_En    = 1'b0;
            IR_En    = 1'b0;
            Acc_En   = 1'b0;
            Rd       = 1'b0;
            Wr       = 1'b0;
            Fetch    = 1'b1;
            Halted   = 1'b0;
        end
    end

endmodule

// File: tb/tb_mu0_control.sv
// Directed bench for mu0_control: one instance with the MemAck handshake and
// one with MEM_HANDSHAKE=0, outputs compared as a packed control vector.
module tb_mu0_control;

    // Vector layout: Fetch Halted M[1:0] X_sel Y_sel Addr_sel PC_En IR_En Acc_En Rd Wr
    localparam logic [11:0] RST_V      = 12'b1_0_00_0_0_0_0_0_0_0_0;
    localparam logic [11:0] FETCH_ACK  = 12'b1_0_10_1_0_0_1_1_0_1_0;
    localparam logic [11:0] FETCH_WAIT = 12'b1_0_10_1_0_0_0_0_0_1_0;
    localparam logic [11:0] LDA_ACK    = 12'b0_0_00_0_0_1_0_0_1_1_0;
    localparam logic [11:0] ADD_ACK    = 12'b0_0_01_0_0_1_0_0_1_1_0;
    localparam logic [11:0] ADD_WAIT   = 12'b0_0_01_0_0_1_0_0_0_1_0;
    localparam logic [11:0] SUB_ACK    = 12'b0_0_11_0_0_1_0_0_1_1_0;
    localparam logic [11:0] STA_V      = 12'b0_0_00_0_0_1_0_0_0_0_1;
    localparam logic [11:0] JMP_T      = 12'b0_0_00_0_1_0_1_0_0_0_0;
    localparam logic [11:0] JMP_NT     = 12'b0_0_00_0_1_0_0_0_0_0_0;
    localparam logic [11:0] IDLE_V     = 12'b0_0_00_0_0_0_0_0_0_0_0;
    localparam logic [11:0] HALT_V     = 12'b0_1_00_0_0_0_0_0_0_0_0;

    logic       Clk = 1'b0;
    logic       Reset, MemAck, N, Z;
    logic [3:0] F;
    logic [1:0] M;
    logic       X_sel, Y_sel, Addr_sel, PC_En, IR_En, Acc_En, Rd, Wr, Fetch, Halted;

    logic       Reset_b, MemAck_b;
    logic [3:0] F_b;
    logic [1:0] M_b;
    logic       X_sel_b, Y_sel_b, Addr_sel_b, PC_En_b, IR_En_b, Acc_En_b, Rd_b, Wr_b, Fetch_b, Halted_b;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    always #5 Clk = ~Clk;

    mu0_control #(.MEM_HANDSHAKE(1'b1)) dut (
        .Clk(Clk), .Reset(Reset), .F(F), .N(N), .Z(Z), .MemAck(MemAck),
        .M(M), .X_sel(X_sel), .Y_sel(Y_sel), .Addr_sel(Addr_sel),
        .PC_En(PC_En), .IR_En(IR_En), .Acc_En(Acc_En), .Rd(Rd), .Wr(Wr),
        .Fetch(Fetch), .Halted(Halted)
    );

    mu0_control #(.MEM_HANDSHAKE(1'b0)) dut_nohs (
        .Clk(Clk), .Reset(Reset_b), .F(F_b), .N(1'b0), .Z(1'b0), .MemAck(MemAck_b),
        .M(M_b), .X_sel(X_sel_b), .Y_sel(Y_sel_b), .Addr_sel(Addr_sel_b),
        .PC_En(PC_En_b), .IR_En(IR_En_b), .Acc_En(Acc_En_b), .Rd(Rd_b), .Wr(Wr_b),
        .Fetch(Fetch_b), .Halted(Halted_b)
    );

    function automatic logic [11:0] vec_a();
        return {Fetch, Halted, M, X_sel, Y_sel, Addr_sel, PC_En, IR_En, Acc_En, Rd, Wr};
    endfunction

    function automatic logic [11:0] vec_b();
        return {Fetch_b, Halted_b, M_b, X_sel_b, Y_sel_b, Addr_sel_b, PC_En_b, IR_En_b, Acc_En_b, Rd_b, Wr_b};
    endfunction

    task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and checks happen mid-cycle, away from the edge
    task automatic tick();
        @(posedge Clk);
        #2;
    endtask

    initial begin
        Reset = 1'b1; MemAck = 1'b0; F = 4'h0; N = 1'b0; Z = 1'b0;
        Reset_b = 1'b1; MemAck_b = 1'b0; F_b = 4'h0;

        #1 check("reset", vec_a(), RST_V);
        MemAck = 1'b1;
        tick();
        #1 check("reset_held_ack", vec_a(), RST_V);

        // LDA with MemAck held high
        Reset = 1'b0;
        #1 check("fetch1", vec_a(), FETCH_ACK);
        tick();
        #1 check("lda_exec", vec_a(), LDA_ACK);
        tick();
        #1 check("fetch_after_lda", vec_a(), FETCH_ACK);

        // Three fetch wait cycles
        MemAck = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 check($sformatf("fetch_wait%0d", i), vec_a(), FETCH_WAIT);
            tick();
        end
        MemAck = 1'b1;
        F = 4'h5; N = 1'b1;
        #1 check("fetch_ack_late", vec_a(), FETCH_ACK);
        tick();

        // Conditional jumps
        #1 check("jge_n1", vec_a(), JMP_NT);
        tick();
        #1 check("fetch_after_jge_n1", vec_a(), FETCH_ACK);
        tick();
        N = 1'b0;
        #1 check("jge_n0", vec_a(), JMP_T);
        tick();
        F = 4'h6; Z = 1'b1;
        #1 check("fetch_after_jge_n0", vec_a(), FETCH_ACK);
        tick();
        #1 check("jne_z1", vec_a(), JMP_NT);
        tick();
        F = 4'h4; Z = 1'b0;
        #1 check("fetch_after_jne", vec_a(), FETCH_ACK);
        tick();
        N = 1'b1; Z = 1'b1;
        #1 check("jmp", vec_a(), JMP_T);
        tick();

        // STA with two wait cycles
        F = 4'h1;
        #1 check("fetch_before_sta", vec_a(), FETCH_ACK);
        tick();
        MemAck = 1'b0;
        #1 check("sta_wait0", vec_a(), STA_V);
        tick();
        #1 check("sta_wait1", vec_a(), STA_V);
        tick();
        MemAck = 1'b1;
        #1 check("sta_ack", vec_a(), STA_V);
        tick();

        // ADD, SUB, undefined opcode
        F = 4'h2;
        #1 check("fetch_after_sta", vec_a(), FETCH_ACK);
        tick();
        #1 check("add_exec", vec_a(), ADD_ACK);
        tick();
        F = 4'h3;
        tick();
        #1 check("sub_exec", vec_a(), SUB_ACK);
        tick();
        F = 4'hA;
        tick();
        #1 check("nop_exec", vec_a(), IDLE_V);
        tick();
        F = 4'h7;
        #1 check("fetch_after_nop", vec_a(), FETCH_ACK);
        tick();

        // STP then HALT with MemAck toggling
        #1 check("stp_exec", vec_a(), IDLE_V);
        tick();
        for (int i = 0; i < 20; i++) begin
            MemAck = i[0];
            F = 4'(i);
            #1 check($sformatf("halt%0d", i), vec_a(), HALT_V);
            tick();
        end
        Reset = 1'b1;
        #1 check("halt_reset", vec_a(), RST_V);
        Reset = 1'b0; MemAck = 1'b1; F = 4'h2;
        #1 check("halt_reset_release", vec_a(), FETCH_ACK);
        tick();

        // Async reset during ADD waiting on MemAck
        MemAck = 1'b0;
        #1 check("add_wait0", vec_a(), ADD_WAIT);
        tick();
        #1 check("add_wait1", vec_a(), ADD_WAIT);
        Reset = 1'b1;
        #1 check("add_async_reset", vec_a(), RST_V);
        Reset = 1'b0;
        #1 check("add_reset_release", vec_a(), FETCH_WAIT);
        tick();
        #1 check("fetch_after_abort", vec_a(), FETCH_WAIT);

        // No-handshake instance: MemAck held low, every access completes in one cycle
        #1 check("nohs_reset", vec_b(), RST_V);
        Reset_b = 1'b0; F_b = 4'h0;
        #1 check("nohs_fetch", vec_b(), FETCH_ACK);
        tick();
        #1 check("nohs_lda", vec_b(), LDA_ACK);
        tick();
        F_b = 4'h1;
        #1 check("nohs_fetch2", vec_b(), FETCH_ACK);
        tick();
        #1 check("nohs_sta", vec_b(), STA_V);
        tick();
        #1 check("nohs_fetch3", vec_b(), FETCH_ACK);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
